// File: rtl/riscv_mc_control.sv
`default_nettype none
// ============================================================================
// Module : riscv_mc_control
// Multicycle RV32I-subset control unit: sequencing FSM, ALU decode, trap.
// Rev    : 1.0
// ============================================================================
module riscv_mc_control #(
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;

  // A 3-bit ALU has no encoding for sra/sltu, so those are treated as illegal.
  localparam bit NARROW_ALU = (ALU_CTRL_W < 4);

  state_t     state_q, state_d;
  logic [3:0] f3_code;
  logic [3:0] alu_code;
  logic       illegal_dec;
  logic       br_taken;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    f3_code = ALU_ADD;
    case (funct3)
      3'b000:  f3_code = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_code = ALU_SLL;
      3'b010:  f3_code = ALU_SLT;
      3'b011:  f3_code = ALU_SLTU;
      3'b100:  f3_code = ALU_XOR;
      3'b101:  f3_code = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  f3_code = ALU_OR;
      default: f3_code = ALU_AND;
    endcase
  end

  always_comb begin
    illegal_dec = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: illegal_dec = (funct3 != 3'b010);
      OP_BR:             illegal_dec = !(funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      OP_R, OP_I:        illegal_dec = NARROW_ALU && ((f3_code == ALU_SRA) || (f3_code == ALU_SLTU));
      OP_JAL, OP_LUI:    illegal_dec = 1'b0;
      default:           illegal_dec = 1'b1;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    alu_code   = ALU_ADD;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        if (illegal_dec) begin
          state_d = S_TRAP;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_I:              state_d = S_EXECI;
            OP_JAL:            state_d = S_JAL;
            OP_BR:             state_d = S_BRANCH;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_code  = f3_code;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_code  = f3_code;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        imm_src   = IMM_J;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_code  = ALU_SUB;
        imm_src   = IMM_B;
        pc_write  = br_taken;
        state_d   = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase

    // Reset must suppress every side effect even mid-access.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
      illegal   = 1'b0;
    end
  end

  generate
    if (ALU_CTRL_W == 3) begin : g_alu_narrow
      logic unused_alu_msb;
      assign unused_alu_msb = alu_code[3];
      assign alu_control    = alu_code[2:0];
    end else begin : g_alu_wide
      assign alu_control = alu_code[ALU_CTRL_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/riscv_mc_control.md
RISCV_MC_CONTROL -- requirements
Module: riscv_mc_control

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 3, meaning alu_control width; legal values 3 or 4.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports op  in  7, funct3  in  3, funct7b5  in  1: instruction fields, valid from DECODE onward.
REQ-005 SHALL have ports zero  in  1 (ALU result == 0) and lt  in  1 (ALU signed less-than).
REQ-006 SHALL have port mem_ready  in  1  memory access complete this cycle.
REQ-007 SHALL have outputs: pc_write 1, adr_src 1, mem_req 1, mem_write 1, ir_write 1, reg_write 1.
REQ-008 SHALL have outputs result_src 2, alu_src_a 2, alu_src_b 2, imm_src 3, alu_control ALU_CTRL_W, and illegal 1.

Function
REQ-009 SHALL implement an FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, LUI, TRAP.
REQ-010 Encodings SHALL be: alu_src_a 00 PC, 01 oldPC, 10 rs1, 11 zero; alu_src_b 00 rs2, 01 imm, 10 const 4; result_src 00 ALUOut, 01 data, 10 ALUResult; imm_src 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-011 FETCH SHALL drive mem_req=1, adr_src=0, srcA 00, srcB 10, add, result_src 10; ir_write=pc_write=mem_ready; stay in FETCH until mem_ready=1, then go to DECODE.
REQ-012 DECODE SHALL drive srcA 01, srcB 01, add, imm_src B; next by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1101111 JAL, 1100011 BRANCH, 0110111 LUI, any other TRAP.
REQ-013 MEMADR SHALL drive srcA 10, srcB 01, add, imm_src I (load) or S (store); next MEMREAD for load, MEMWRITE for store.
REQ-014 MEMREAD SHALL drive mem_req=1, adr_src=1, result_src 00; hold until mem_ready, then MEMWB; MEMWB SHALL drive result_src 01, reg_write=1, then FETCH.
REQ-015 MEMWRITE SHALL drive mem_req=1, mem_write=1, adr_src=1, result_src 00; hold until mem_ready, then FETCH.
REQ-016 EXECR (srcA 10, srcB 00) and EXECI (srcA 10, srcB 01, imm_src I) SHALL use funct3 decode and go to ALUWB; ALUWB SHALL drive result_src 00, reg_write=1, then FETCH.
REQ-017 JAL SHALL drive srcA 01, srcB 10, add, result_src 00, pc_write=1, imm_src J, then ALUWB.
REQ-018 LUI SHALL drive srcA 11, srcB 01, add, imm_src U, then ALUWB.
REQ-019 BRANCH SHALL drive srcA 10, srcB 00, sub, result_src 00, imm_src B, then FETCH; pc_write = taken, where funct3 000 taken=zero, 001 ~zero, 100 lt, 101 ~lt.
REQ-020 alu_control codes (zero-extended) SHALL be: add 0, sub 1, and 2, or 3, xor 4, slt 5, sll 6, srl 7, sra 8, sltu 9.
REQ-021 funct3 decode SHALL map 000 add (sub if op[5]&funct7b5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if funct7b5), 110 or, 111 and.
REQ-022 Illegal, decided in DECODE, SHALL go to TRAP: unknown op; load/store funct3 != 010; branch funct3 not in {000,001,100,101}; sra or sltu when ALU_CTRL_W=3.
REQ-023 TRAP SHALL hold illegal=1 and all enables (pc_write, ir_write, reg_write, mem_write, mem_req) 0; it SHALL be exited only by rst.
REQ-024 Outputs not listed for a state SHALL be 0; outputs are combinational from state plus mem_ready, zero, lt, and the instruction fields.
REQ-025 Instruction latency with zero wait states SHALL be: lw 5, sw 4, R/I/LUI/JAL 4, branch 3 cycles.

Reset
REQ-026 With rst=1 at a clk edge, state SHALL become FETCH, overriding any in-flight access or wait.
REQ-027 While rst=1, pc_write, ir_write, reg_write, mem_write, mem_req and illegal SHALL be 0 combinationally.

Verification
REQ-028 Reset, then add (op 0110011, funct3 000, f7b5 0), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_control 0; reg_write=1 in cycle 4 only.
REQ-029 lw with mem_ready held low 3 cycles in MEMREAD -> mem_req=1, adr_src=1 throughout; MEMWB after mem_ready; reg_write=1 exactly once.
REQ-030 bne with zero=0 -> pc_write=1 in BRANCH; with zero=1 -> pc_write=0; alu_control 1 in both cases.
REQ-031 sra (funct3 101, f7b5 1): ALU_CTRL_W=4 -> alu_control 4'b1000; ALU_CTRL_W=3 -> TRAP, illegal=1, all enables 0.
REQ-032 Unknown op 1111111 -> TRAP with illegal held; assert rst mid-TRAP and mid-MEMWRITE wait -> FETCH next cycle, mem_write=0 during reset.
